// File: rtl/oai22_stim_pkg.sv
// Shared types and constants for the OAI22X1 stimulus-and-check stage.
// Also holds the golden model of the cell used to score each sampled QN.
package oai22_stim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StFin
  } state_e;

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_GRAY  = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;

  // Fibonacci x^4 + x^3 + 1: feedback is vec[3] ^ vec[2], shifted in at bit 0.
  localparam logic [3:0] LFSR_SEED = 4'b0001;
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  function automatic logic oai22_exp(input logic [3:0] vec);
    return ~((vec[0] | vec[1]) & (vec[2] | vec[3]));
  endfunction

endpackage

// File: rtl/oai22_pattern_src.sv
// Pattern source: index counter plus 4-bit LFSR, muxed by the mode latched on load.
// vec is combinational from the held state; the caller registers it onto the cell pins.
module oai22_pattern_src
  import oai22_stim_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic       adv,
  input  logic [1:0] mode,
  output logic [3:0] vec
);

  logic [1:0] mode_q;
  logic [3:0] idx_q;
  logic [3:0] lfsr_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q <= 2'd0;
      idx_q  <= 4'd0;
      lfsr_q <= 4'd0;
    end else if (load) begin
      mode_q <= mode;
      idx_q  <= 4'd0;
      lfsr_q <= LFSR_SEED;
    end else if (adv) begin
      idx_q  <= idx_q + 4'd1;
      lfsr_q <= {lfsr_q[2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_comb begin
    vec = idx_q;
    case (mode_q)
      MODE_GRAY: vec = idx_q ^ (idx_q >> 1);
      MODE_LFSR: vec = lfsr_q;
      default:   vec = idx_q;
    endcase
  end

endmodule

// File: rtl/oai22_stim_chk.sv
// Drives an OAI22X1 cell from a selectable pattern and scores its QN against the golden
// model: ones, toggle and mismatch counts, all saturating.
module oai22_stim_chk
  import oai22_stim_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       MODE,
  output logic             OUT1,
  output logic             OUT2,
  output logic             OUT3,
  output logic             OUT4,
  input  logic             QN_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] ONES_CNT,
  output logic [CNT_W-1:0] TOGGLE_CNT,
  output logic [CNT_W-1:0] MISMATCH_CNT
);

  localparam logic [15:0]      LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [15:0]      vidx_q;
  logic [3:0]       out_q;
  logic             drv_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       vec;
  logic             accept;
  logic             adv;

  logic             qn_s_q;
  logic [3:0]       vec_s_q;
  logic             valid_s_q;
  logic             qn_prev_q;
  logic             first_q;
  logic [CNT_W-1:0] ones_q;
  logic [CNT_W-1:0] toggle_q;
  logic [CNT_W-1:0] mism_q;

  // DONE is still high in the first IDLE cycle; blocking accept there keeps START in FIN inert.
  assign accept = (state_q == StIdle) && START && !done_q;
  assign adv    = (state_q == StRun);

  oai22_pattern_src u_src (
    .CLK  (CLK),
    .RST  (RST),
    .load (accept),
    .adv  (adv),
    .mode (MODE),
    .vec  (vec)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      vidx_q  <= 16'd0;
      out_q   <= 4'd0;
      drv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StRun;
            vidx_q  <= 16'd0;
          end
        end
        StRun: begin
          out_q  <= vec;
          drv_q  <= 1'b1;
          busy_q <= 1'b1;
          vidx_q <= vidx_q + 16'd1;
          if (vidx_q == LAST_IDX) state_q <= StDrain;
        end
        StDrain: begin
          out_q   <= 4'd0;
          drv_q   <= 1'b0;
          state_q <= StFin;
        end
        StFin: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Capture the vector on the pins with the QN it produced, then score it a cycle later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      qn_s_q    <= 1'b0;
      vec_s_q   <= 4'd0;
      valid_s_q <= 1'b0;
      qn_prev_q <= 1'b0;
      first_q   <= 1'b0;
      ones_q    <= '0;
      toggle_q  <= '0;
      mism_q    <= '0;
    end else begin
      qn_s_q    <= QN_IN;
      vec_s_q   <= out_q;
      valid_s_q <= drv_q;
      if (accept) begin
        valid_s_q <= 1'b0;
        first_q   <= 1'b1;
        ones_q    <= '0;
        toggle_q  <= '0;
        mism_q    <= '0;
      end else if (valid_s_q) begin
        if (qn_s_q && ones_q != '1) ones_q <= ones_q + CNT_ONE;
        if ((qn_s_q != oai22_exp(vec_s_q)) && mism_q != '1) mism_q <= mism_q + CNT_ONE;
        if (!first_q && (qn_s_q != qn_prev_q) && toggle_q != '1) toggle_q <= toggle_q + CNT_ONE;
        qn_prev_q <= qn_s_q;
        first_q   <= 1'b0;
      end
    end
  end

  assign OUT1         = out_q[0];
  assign OUT2         = out_q[1];
  assign OUT3         = out_q[2];
  assign OUT4         = out_q[3];
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign ONES_CNT     = ones_q;
  assign TOGGLE_CNT   = toggle_q;
  assign MISMATCH_CNT = mism_q;

endmodule
